opcode_sequencer: RTL and testbench

Control sequencer that buffers incoming 5-bit opcodes, decodes each into a one-hot command (opcodes 0-5 → cmd_out[0..5]) and holds it until the execution unit acknowledges completion. It sits between the instruction source and the execution units, serializing commands one at a time. It also detects illegal opcodes (6-31) and reports them.

---
 rtl/opcode_sequencer_if.sv | 26 ++
 rtl/opcode_sequencer.sv | 117 +++++++++++
 tb/tb_opcode_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/opcode_sequencer_if.sv
// Handshake bundle between the instruction source / execution unit and opcode_sequencer.
// slave = sequencer side, master = source/execution-unit side.
interface opcode_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             op_valid;
    logic [4:0]       op_in;
    logic             op_ready;
    logic             cmd_valid;
    logic [5:0]       cmd_out;
    logic             cmd_done;
    logic             busy;
    logic             illegal;
    logic             trap_clr;
    logic [CNT_W-1:0] issued_cnt;

    modport slave (
        input  op_valid, op_in, cmd_done, trap_clr,
        output op_ready, cmd_valid, cmd_out, busy, illegal, issued_cnt
    );

    modport master (
        output op_valid, op_in, cmd_done, trap_clr,
        input  op_ready, cmd_valid, cmd_out, busy, illegal, issued_cnt
    );
endinterface

// File: rtl/opcode_sequencer.sv
// Buffers 5-bit opcodes in a small FIFO and issues them one at a time as one-hot commands.
// Define OPCODE_SEQ_TRAP_EN to stall in TRAP on an illegal opcode until trap_clr.
module opcode_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opcode_sequencer_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef OPCODE_SEQ_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

    state_t           r_state, w_next_state;
    logic [4:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_cmd_valid;
    logic [5:0]       r_cmd_out;
    logic             r_illegal;
    logic [CNT_W-1:0] r_issued;

    logic             w_full, w_empty, w_push, w_pop, w_done, w_set_ill;
    logic [4:0]       w_head;
    logic             w_head_legal;

    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = bus.op_valid && !w_full;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_legal = (w_head < 5'd6);
    assign w_done       = (r_state == S_EXEC) && bus.cmd_done;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_set_ill    = 1'b0;
        case (r_state)
            S_IDLE: w_pop = !w_empty;
            S_EXEC: begin
                w_pop = w_done && !w_empty;
                if (w_done && w_empty) w_next_state = S_IDLE;
            end
`ifdef OPCODE_SEQ_TRAP_EN
            S_TRAP: if (bus.trap_clr) w_next_state = S_IDLE;
`endif
            default: w_next_state = S_IDLE;
        endcase
        // A pop decides the next state from the head opcode, in IDLE and back-to-back alike
        if (w_pop) begin
            if (w_head_legal) begin
                w_next_state = S_EXEC;
            end else begin
                w_set_ill = 1'b1;
`ifdef OPCODE_SEQ_TRAP_EN
                w_next_state = S_TRAP;
`else
                w_next_state = S_IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.op_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_out   <= '0;
            r_illegal   <= 1'b0;
            r_issued    <= '0;
        end else begin
            r_cmd_valid <= (w_next_state == S_EXEC);
            if (w_pop && w_head_legal)
                r_cmd_out <= 6'b000001 << w_head[2:0];
            else if (w_next_state != S_EXEC)
                r_cmd_out <= '0;
            if (w_set_ill)
                r_illegal <= 1'b1;
            else if (bus.trap_clr)
                r_illegal <= 1'b0;
            if (w_done) r_issued <= r_issued + 1'b1;
        end
    end

    assign bus.op_ready   = !w_full;
    assign bus.busy       = !w_empty || r_cmd_valid;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.cmd_out    = r_cmd_out;
    assign bus.illegal    = r_illegal;
    assign bus.issued_cnt = r_issued;
endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed-vector bench for opcode_sequencer (DEPTH=4, CNT_W=8); inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_opcode_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    opcode_sequencer_if #(.CNT_W(8)) bus ();

    opcode_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [5] = '{32'h01, 32'h02, 32'h04, 32'h10, 32'h20};
    int ops_seq [5] = '{0, 1, 2, 4, 5};
    int fill_op [5] = '{1, 2, 3, 4, 0};

    initial begin
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_in    = '0;
        bus.cmd_done = 1'b0;
        bus.trap_clr = 1'b0;
        tick(); tick();
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_cmd_out",   32'(bus.cmd_out), 0);
        chk("rst_illegal",   32'(bus.illegal), 0);
        chk("rst_issued",    32'(bus.issued_cnt), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_op_ready",  32'(bus.op_ready), 1);
        rst_n = 1'b1;
        tick();

        // single opcode 3: accepted, popped next edge, then completed
        bus.op_valid = 1'b1; bus.op_in = 5'd3;
        tick();
        bus.op_valid = 1'b0;
        chk("t1_valid_early", 32'(bus.cmd_valid), 0);
        chk("t1_busy",        32'(bus.busy), 1);
        tick();
        chk("t1_valid", 32'(bus.cmd_valid), 1);
        chk("t1_cmd",   32'(bus.cmd_out), 32'h08);
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        chk("t1_valid_off", 32'(bus.cmd_valid), 0);
        chk("t1_issued",    32'(bus.issued_cnt), 1);
        chk("t1_idle_busy", 32'(bus.busy), 0);

        // back-to-back with cmd_done held high
        bus.cmd_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                bus.op_valid = 1'b1; bus.op_in = 5'(ops_seq[i]);
            end else begin
                bus.op_valid = 1'b0;
            end
            tick();
            if (i >= 1) chk($sformatf("t2_cmd%0d", i - 1), 32'(bus.cmd_out), 32'(exp_seq[i - 1]));
        end
        tick();
        bus.cmd_done = 1'b0;
        chk("t2_idle",   32'(bus.cmd_valid), 0);
        chk("t2_issued", 32'(bus.issued_cnt), 6);

        // fill: one executing, four buffered, sixth push held off
        for (int i = 0; i < 5; i++) begin
            bus.op_valid = 1'b1; bus.op_in = 5'(fill_op[i]);
            tick();
        end
        chk("t3_full_ready", 32'(bus.op_ready), 0);
        chk("t3_cmd",        32'(bus.cmd_out), 32'h02);
        bus.op_in = 5'd5;
        tick();
        chk("t3_still_full", 32'(bus.op_ready), 0);
        bus.cmd_done = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        chk("t3_ready_back", 32'(bus.op_ready), 1);
        chk("t3_cmd2",       32'(bus.cmd_out), 32'h04);
        tick(); chk("t3_cmd3", 32'(bus.cmd_out), 32'h08);
        tick(); chk("t3_cmd4", 32'(bus.cmd_out), 32'h10);
        tick(); chk("t3_cmd0", 32'(bus.cmd_out), 32'h01);
        tick();
        bus.cmd_done = 1'b0;
        chk("t3_drained_busy", 32'(bus.busy), 0);
        chk("t3_issued",       32'(bus.issued_cnt), 11);

        // illegal opcode 7 followed by 2
        bus.op_valid = 1'b1; bus.op_in = 5'd7;
        tick();
        bus.op_in = 5'd2;
        tick();
        bus.op_valid = 1'b0;
        chk("t4_illegal", 32'(bus.illegal), 1);
        chk("t4_no_cmd",  32'(bus.cmd_valid), 0);
        tick();
`ifdef OPCODE_SEQ_TRAP_EN
        chk("t4_stall",      32'(bus.cmd_valid), 0);
        chk("t4_stall_busy", 32'(bus.busy), 1);
        bus.trap_clr = 1'b1;
        tick();
        bus.trap_clr = 1'b0;
        chk("t4_clr", 32'(bus.illegal), 0);
        tick();
        chk("t4_cmd", 32'(bus.cmd_out), 32'h04);
`else
        chk("t4_cmd",    32'(bus.cmd_out), 32'h04);
        chk("t4_sticky", 32'(bus.illegal), 1);
        bus.trap_clr = 1'b1;
        tick();
        bus.trap_clr = 1'b0;
        chk("t4_clr",          32'(bus.illegal), 0);
        chk("t4_cmd_held",     32'(bus.cmd_out), 32'h04);
`endif
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        chk("t4_issued", 32'(bus.issued_cnt), 12);

        // reset while executing with three buffered
        for (int i = 0; i < 4; i++) begin
            bus.op_valid = 1'b1; bus.op_in = 5'(i + 1);
            tick();
        end
        bus.op_valid = 1'b0;
        chk("t5_pre_valid", 32'(bus.cmd_valid), 1);
        rst_n = 1'b0;
        tick();
        chk("t5_valid",  32'(bus.cmd_valid), 0);
        chk("t5_cmd",    32'(bus.cmd_out), 0);
        chk("t5_busy",   32'(bus.busy), 0);
        chk("t5_ready",  32'(bus.op_ready), 1);
        chk("t5_issued", 32'(bus.issued_cnt), 0);
        rst_n = 1'b1;
        tick();
        chk("t5_stay_idle", 32'(bus.busy), 0);

        // counter wrap: completions on edges 3..259 total 257
        bus.op_valid = 1'b1; bus.op_in = 5'd0; bus.cmd_done = 1'b1;
        for (int i = 0; i < 257; i++) tick();
        chk("t6_cnt255", 32'(bus.issued_cnt), 255);
        bus.op_valid = 1'b0;
        tick();
        chk("t6_wrap", 32'(bus.issued_cnt), 0);
        tick();
        bus.cmd_done = 1'b0;
        chk("t6_after_wrap", 32'(bus.issued_cnt), 1);
        chk("t6_idle",       32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
